// File: rtl/cond_flag_unit.sv
// cond_flag_unit
//   Condition/flag stage that sits directly after the ALU.
//   It holds the architectural NZCV register and evaluates each instruction's ARM condition
//   field against the registered flags. From that result it gates the PC, register-file and
//   memory write enables. It also returns the registered carry to the ALU.
//
// Optional feature
//   COND_PERF_CNT_EN (macro)
//     Builds saturating counters of executed and skipped instructions.
//     When the macro is undefined, ExecCount and SkipCount are tied to zero.
//
// Parameters
//   FLAG_RESET  reset value of {N,Z,C,V}
//   PERF_W      width of each performance counter
//
// Ports
//   CLK, RESET      rising-edge clock; asynchronous active-high reset
//   InstrValid      an instruction is presented this cycle
//   Cond            ARM condition field
//   ALUFlags        {N,Z,C,V} produced by the ALU for this instruction
//   FlagW           [1] update N,Z; [0] update C (and V when IsArithmeticOp)
//   IsArithmeticOp  ADD/SUB-class instruction; only these may write V
//   PCS/RegW/MemW   raw write intents from the decoder
//   NoWrite         compare-class instruction; suppress register write
//   Stall, Flush    hold state / squash current instruction
//   PCSrc, RegWrite, MemWrite  gated write enables (combinational)
//   CondEx          condition pass (combinational)
//   C_Flag          registered carry bit, returned to the ALU
//   Flags           registered {N,Z,C,V}
//   ExecCount, SkipCount       performance counters
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter int         PERF_W     = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              InstrValid,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              IsArithmeticOp,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  input  logic              Stall,
  input  logic              Flush,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
  output logic              C_Flag,
  output logic [3:0]        Flags,
  output logic [PERF_W-1:0] ExecCount,
  output logic [PERF_W-1:0] SkipCount
);

  // ARM condition table; nzcv is {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;  // 4'b1111: never
    endcase
    return res;
  endfunction

  logic [3:0] flags_r;
  logic [3:0] flags_nxt_s;
  logic       cond_ex_s;
  logic       upd_en_s;
  logic       count_en_s;

  // Evaluation always uses the pre-update registered flags, never this cycle's ALUFlags.
  assign cond_ex_s  = InstrValid & cond_eval(Cond, flags_r);
  assign upd_en_s   = cond_ex_s & ~Stall & ~Flush;
  assign count_en_s = InstrValid & ~Stall & ~Flush;

  assign CondEx   = cond_ex_s;
  assign PCSrc    = PCS  & cond_ex_s & ~Flush;
  assign RegWrite = RegW & cond_ex_s & ~NoWrite & ~Flush;
  assign MemWrite = MemW & cond_ex_s & ~Flush;
  assign Flags    = flags_r;
  assign C_Flag   = flags_r[1];

  // Next flag value: per-field merge of ALUFlags; logical S-ops leave V untouched.
  always_comb begin
    flags_nxt_s = flags_r;
    if (FlagW[1]) begin
      flags_nxt_s[3:2] = ALUFlags[3:2];
    end else begin
      flags_nxt_s[3:2] = flags_r[3:2];
    end
    if (FlagW[0]) begin
      flags_nxt_s[1] = ALUFlags[1];
    end else begin
      flags_nxt_s[1] = flags_r[1];
    end
    if (FlagW[0] & IsArithmeticOp) begin
      flags_nxt_s[0] = ALUFlags[0];
    end else begin
      flags_nxt_s[0] = flags_r[0];
    end
  end

  // Architectural NZCV register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flags_r <= FLAG_RESET;
    end else if (upd_en_s) begin
      flags_r <= flags_nxt_s;
    end
  end

`ifdef COND_PERF_CNT_EN
  localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};

  logic [PERF_W-1:0] exec_cnt_r;
  logic [PERF_W-1:0] skip_cnt_r;

  // Saturating executed/skipped counters; stalled or flushed slots are not counted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      exec_cnt_r <= {PERF_W{1'b0}};
      skip_cnt_r <= {PERF_W{1'b0}};
    end else if (count_en_s) begin
      if (cond_ex_s) begin
        if (exec_cnt_r != CNT_MAX) begin
          exec_cnt_r <= exec_cnt_r + PERF_W'(1);
        end
      end else begin
        if (skip_cnt_r != CNT_MAX) begin
          skip_cnt_r <= skip_cnt_r + PERF_W'(1);
        end
      end
    end
  end

  assign ExecCount = exec_cnt_r;
  assign SkipCount = skip_cnt_r;
`else
  logic unused_cnt_s;
  assign unused_cnt_s = count_en_s;
  assign ExecCount    = {PERF_W{1'b0}};
  assign SkipCount    = {PERF_W{1'b0}};
`endif

endmodule
